// File: rtl/dphy_timer_bank_if.sv
// dphy_timer_bank_if: control and status bundle between the lane FSMs and the timer bank.
interface dphy_timer_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int PRESC_W  = 4
);
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS-1:0]       abort;
    logic [CHANNELS-1:0]       periodic;
    logic [CHANNELS*WIDTH-1:0] load_val;
    logic [PRESC_W-1:0]        prescale;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       expire;
    logic                      any_expire;
    modport master (
        output start, abort, periodic, load_val, prescale,
        input  busy, expire, any_expire
    );
    modport slave (
        input  start, abort, periodic, load_val, prescale,
        output busy, expire, any_expire
    );
endinterface

// File: rtl/dphy_timer_bank.sv
// dphy_timer_bank: independent prescaled down-counting timers with one-shot/periodic expiry pulses.
module dphy_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int PRESC_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    dphy_timer_bank_if.slave    bus_io
);
    typedef enum logic {IDLE, RUN} state_e;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic [CHANNELS-1:0] expire_d;
    logic                any_expire_q;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_e             state_q, state_d;
        logic [WIDTH-1:0]   count_q, count_d, reload_q, reload_d, lv;
        logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d, p_reg_q, p_reg_d;
        logic               mode_q, mode_d, exp_q, exp_d, tick;
        assign lv = bus_io.load_val[c*WIDTH +: WIDTH];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q     <= IDLE;
                count_q     <= '0;
                reload_q    <= '0;
                presc_cnt_q <= '0;
                p_reg_q     <= '0;
                mode_q      <= 1'b0;
                exp_q       <= 1'b0;
            end else begin
                state_q     <= state_d;
                count_q     <= count_d;
                reload_q    <= reload_d;
                presc_cnt_q <= presc_cnt_d;
                p_reg_q     <= p_reg_d;
                mode_q      <= mode_d;
                exp_q       <= exp_d;
            end
        end
        // abort beats start, start beats a pending tick/expiry
        always_comb begin
            state_d     = state_q;
            count_d     = count_q;
            reload_d    = reload_q;
            presc_cnt_d = presc_cnt_q;
            p_reg_d     = p_reg_q;
            mode_d      = mode_q;
            exp_d       = 1'b0;
            tick        = state_q == RUN && presc_cnt_q == p_reg_q;
            if (bus_io.abort[c]) begin
                state_d = IDLE;
            end else if (bus_io.start[c]) begin
                reload_d    = lv == '0 ? ONE : lv;
                count_d     = lv == '0 ? ONE : lv;
                p_reg_d     = bus_io.prescale;
                presc_cnt_d = '0;
                mode_d      = bus_io.periodic[c];
                state_d     = RUN;
            end else if (state_q == RUN) begin
                presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
                if (tick) begin
                    exp_d   = count_q == ONE;
                    count_d = count_q == ONE ? (mode_q ? reload_q : count_q) : count_q - 1'b1;
                    state_d = count_q == ONE && !mode_q ? IDLE : RUN;
                end
            end
        end
        assign expire_d[c]      = exp_d;
        assign bus_io.expire[c] = exp_q;
        assign bus_io.busy[c]   = state_q == RUN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) any_expire_q <= 1'b0;
        else     any_expire_q <= |expire_d;
    end
    assign bus_io.any_expire = any_expire_q;
endmodule

// File: tb/tb_dphy_timer_bank.sv
// tb_dphy_timer_bank: directed test-plan scenarios plus random traffic against a deadline-based model.
module tb_dphy_timer_bank;
    localparam int CH = 4, W = 16, PW = 4;
    logic clk = 1'b0, rst = 1'b1;
    int n_cmp = 0, n_bad = 0, e = 0;
    dphy_timer_bank_if #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) bus ();
    dphy_timer_bank #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) dut (.clk(clk), .rst(rst), .bus_io(bus));
    always #5 clk = ~clk;
    // model: each active channel holds the absolute edge number of its next expiry
    bit m_act[CH], m_mode[CH];
    int m_due[CH], m_len[CH];
    logic [CH-1:0] m_exp;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask
    function automatic logic [CH-1:0] m_busy();
        logic [CH-1:0] b;
        for (int c = 0; c < CH; c++) b[c] = m_act[c];
        return b;
    endfunction
    task automatic cyc(input logic [CH-1:0] s, input logic [CH-1:0] a, input logic [CH-1:0] per,
                       input logic [CH*W-1:0] lv, input logic [PW-1:0] p);
        int n;
        bus.start = s; bus.abort = a; bus.periodic = per; bus.load_val = lv; bus.prescale = p;
        @(posedge clk);
        e++;
        for (int c = 0; c < CH; c++) begin
            m_exp[c] = 1'b0;
            n = int'(lv[c*W +: W]);
            if (n == 0) n = 1;
            if (a[c]) m_act[c] = 0;
            else if (s[c]) begin
                m_len[c] = n * (int'(p) + 1);
                m_due[c] = e + m_len[c];
                m_mode[c] = per[c];
                m_act[c] = 1;
            end else if (m_act[c] && e == m_due[c]) begin
                m_exp[c] = 1'b1;
                if (m_mode[c]) m_due[c] += m_len[c];
                else m_act[c] = 0;
            end
        end
        #1;
        check("busy", 32'(bus.busy), 32'(m_busy()));
        check("expire", 32'(bus.expire), 32'(m_exp));
        check("any_expire", 32'(bus.any_expire), 32'(|m_exp));
        @(negedge clk);
    endtask
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc('0, '0, '0, '0, '0);
    endtask
    function automatic logic [CH*W-1:0] lvs(input int n0, input int n1, input int n2, input int n3);
        logic [CH*W-1:0] v;
        v = {W'(n3), W'(n2), W'(n1), W'(n0)};
        return v;
    endfunction
    initial begin
        logic [CH-1:0] s, a, per;
        logic [CH*W-1:0] lv;
        bus.start = '0; bus.abort = '0; bus.periodic = '0; bus.load_val = '0; bus.prescale = '0;
        for (int c = 0; c < CH; c++) begin m_act[c] = 0; m_due[c] = 0; m_len[c] = 0; m_mode[c] = 0; end
        m_exp = '0;
        #2;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_expire", 32'(bus.expire), 0);
        check("reset_any", 32'(bus.any_expire), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle(9);
        cyc(4'b0001, '0, '0, lvs(5, 0, 0, 0), 0);
        idle(10);
        cyc(4'b0010, '0, 4'b0010, lvs(0, 3, 0, 0), 2);
        idle(19);
        cyc('0, 4'b0010, '0, '0, 0);
        idle(10);
        cyc(4'b0100, '0, '0, lvs(0, 0, 0, 0), 0);
        idle(3);
        cyc(4'b0100, '0, '0, lvs(0, 0, 0, 0), 3);
        idle(7);
        cyc(4'b0001, '0, '0, lvs(4, 0, 0, 0), 0);
        idle(3);
        cyc(4'b0001, '0, '0, lvs(4, 0, 0, 0), 0);
        idle(8);
        cyc(4'b1111, 4'b1000, '0, lvs(2, 3, 5, 7), 1);
        idle(14);
        for (int i = 0; i < 10; i++) cyc(4'b0001, '0, '0, lvs(1, 0, 0, 0), 0);
        idle(3);
        cyc(4'b0100, '0, 4'b0100, lvs(0, 0, 1, 0), 0);
        idle(5);
        cyc('0, 4'b0100, '0, '0, 0);
        idle(2);
        cyc(4'b1111, '0, 4'b1010, lvs(3, 1, 2, 1), 0);
        idle(2);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_expire", 32'(bus.expire), 0);
        check("rst_any", 32'(bus.any_expire), 0);
        for (int c = 0; c < CH; c++) m_act[c] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                s[c] = $urandom_range(0, 7) == 0;
                a[c] = $urandom_range(0, 31) == 0;
                per[c] = $urandom_range(0, 1) == 1;
                lv[c*W +: W] = W'($urandom_range(0, 6));
            end
            cyc(s, a, per, lv, PW'($urandom_range(0, 3)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
